fiat_25519_carry_mul_sdiv_32s_6ns_32_seq: RTL and testbench

Sequential signed-by-unsigned divider. It is the inverse datapath of the 32s×6ns multiplier in the fiat_25519_carry_mul datapath.
- Takes a signed dividend (din0) and an unsigned small divisor (din1).
- Returns a C-semantics quotient and remainder: truncate toward zero; the remainder takes the sign of the dividend.
- Restoring algorithm, one quotient bit per cycle, with a valid/ready handshake on both sides.
- Used where limb values must be scaled back down or checked against a small radix factor.

---
 rtl/fiat_25519_carry_mul_sdiv_32s_6ns_32_seq_if.sv | 32 +++
 rtl/fiat_25519_carry_mul_sdiv_32s_6ns_32_seq.sv | 158 +++++++++++++++
 tb/tb_fiat_25519_carry_mul_sdiv_32s_6ns_32_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fiat_25519_carry_mul_sdiv_32s_6ns_32_seq_if.sv
// rtl/fiat_25519_carry_mul_sdiv_32s_6ns_32_seq_if.sv - operand/result handshake bundle for the sequential signed divider
//
// Signals:
//   din_vld/din_rdy  operand handshake; din0 signed dividend, din1 unsigned divisor
//   dout_vld/dout_rdy result handshake; dout signed quotient, rem signed remainder,
//                     dbz divide-by-zero flag (qualified by dout_vld)
// Modports: master = operand producer / result consumer, slave = divider.
interface fiat_25519_carry_mul_sdiv_32s_6ns_32_seq_if #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 32
);
  logic                  din_vld;
  logic                  din_rdy;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  dout_vld;
  logic                  dout_rdy;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH:0]   rem;
  logic                  dbz;

  modport master (
    output din_vld, din0, din1, dout_rdy,
    input  din_rdy, dout_vld, dout, rem, dbz
  );

  modport slave (
    input  din_vld, din0, din1, dout_rdy,
    output din_rdy, dout_vld, dout, rem, dbz
  );
endinterface

// File: rtl/fiat_25519_carry_mul_sdiv_32s_6ns_32_seq.sv
// rtl/fiat_25519_carry_mul_sdiv_32s_6ns_32_seq.sv - restoring signed-by-unsigned divider, one quotient bit per cycle
//
// Ports:
//   ap_clk  rising-edge clock
//   ap_rst  synchronous active-high reset
//   bus     slave side of the operand/result handshake interface
// Optional feature macro: FIAT_SDIV_FASTPATH_EN (resolves din1==0, din1==1 and
//   |din0|<din1 at accept, presenting the result one cycle later).
module fiat_25519_carry_mul_sdiv_32s_6ns_32_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 32
) (
  input logic ap_clk,
  input logic ap_rst,
  fiat_25519_carry_mul_sdiv_32s_6ns_32_seq_if.slave bus
);
  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int PW = W1 + 1;
  localparam int CW = $clog2(W0 + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  wire [31:0] unused_id = ID;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q;
  logic [W0-1:0]         mag_q;   // dividend magnitude, becomes the quotient as it shifts
  logic [W1-1:0]         div_q;
  logic [PW-1:0]         part_q;  // partial remainder
  logic                  din_rdy_q;
  logic                  dout_vld_q;
  logic [dout_WIDTH-1:0] dout_q;
  logic [PW-1:0]         rem_q;
  logic                  dbz_q;

  logic [PW:0]           shift_w;
  logic                  ge_w;
  logic [PW-1:0]         part_d;
  logic [W0-1:0]         mag_d;
  logic [W0-1:0]         abs_w;
  logic                  fast_hit_w;
  logic [W0-1:0]         fast_dout_w;
  logic [PW-1:0]         fast_rem_w;
  logic                  fast_dbz_w;

  always_comb begin
    // One restoring step: one extra bit of headroom so the compare never overflows.
    shift_w = {part_q, mag_q[W0-1]};
    ge_w    = (shift_w >= {2'b00, div_q});
    part_d  = PW'(ge_w ? (shift_w - {2'b00, div_q}) : shift_w);
    mag_d   = {mag_q[W0-2:0], ge_w};
    // -2^(W0-1) maps onto 2^(W0-1), which the unsigned register holds exactly.
    abs_w   = bus.din0[W0-1] ? (~bus.din0 + W0'(1)) : bus.din0;

    fast_hit_w  = 1'b0;
    fast_dout_w = '0;
    fast_rem_w  = '0;
    fast_dbz_w  = 1'b0;
`ifdef FIAT_SDIV_FASTPATH_EN
    if (bus.din1 == '0) begin
      fast_hit_w  = 1'b1;
      fast_dout_w = '1;
      fast_dbz_w  = 1'b1;
    end else if (bus.din1 == W1'(1)) begin
      fast_hit_w  = 1'b1;
      fast_dout_w = bus.din0;
    end else if (abs_w < {{(W0-W1){1'b0}}, bus.din1}) begin
      fast_hit_w  = 1'b1;
      fast_rem_w  = bus.din0[PW-1:0];
    end
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      mag_q      <= '0;
      div_q      <= '0;
      part_q     <= '0;
      din_rdy_q  <= 1'b1;
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          din_rdy_q  <= 1'b1;
          dout_vld_q <= 1'b0;
          if (bus.din_vld && din_rdy_q) begin
            neg_q     <= bus.din0[W0-1];
            mag_q     <= abs_w;
            div_q     <= bus.din1;
            part_q    <= '0;
            cnt_q     <= CW'(W0);
            din_rdy_q <= 1'b0;
            if (fast_hit_w) begin
              dout_q     <= fast_dout_w;
              rem_q      <= fast_rem_w;
              dbz_q      <= fast_dbz_w;
              dout_vld_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          part_q <= part_d;
          mag_q  <= mag_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q    <= S_DONE;
            dout_vld_q <= 1'b1;
            // A zero divisor still runs every step so latency is data-independent.
            if (div_q == '0) begin
              dout_q <= '1;
              rem_q  <= '0;
              dbz_q  <= 1'b1;
            end else begin
              dout_q <= neg_q ? (~mag_d + W0'(1)) : mag_d;
              rem_q  <= neg_q ? (~part_d + PW'(1)) : part_d;
              dbz_q  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (bus.dout_rdy) begin
            state_q    <= S_IDLE;
            dout_vld_q <= 1'b0;
            din_rdy_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          din_rdy_q  <= 1'b1;
          dout_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_rdy  = din_rdy_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.dout     = dout_q;
  assign bus.rem      = rem_q;
  assign bus.dbz      = dbz_q;
endmodule

// File: tb/tb_fiat_25519_carry_mul_sdiv_32s_6ns_32_seq.sv
// tb/tb_fiat_25519_carry_mul_sdiv_32s_6ns_32_seq.sv - scoreboard bench for the sequential signed divider
module tb_fiat_25519_carry_mul_sdiv_32s_6ns_32_seq;
  localparam int LAT_N = 33;
`ifdef FIAT_SDIV_FASTPATH_EN
  localparam int LAT_FP = 1;
`else
  localparam int LAT_FP = 33;
`endif

  typedef struct {
    logic [31:0] dout;
    logic [6:0]  rem;
    logic        dbz;
    int          lat;
  } exp_t;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  fiat_25519_carry_mul_sdiv_32s_6ns_32_seq_if #(
    .din0_WIDTH(32), .din1_WIDTH(6), .dout_WIDTH(32)
  ) bus_if ();

  fiat_25519_carry_mul_sdiv_32s_6ns_32_seq #(
    .ID(1), .din0_WIDTH(32), .din1_WIDTH(6), .dout_WIDTH(32)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus(bus_if)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: latency from accept to dout_vld rise, values checked at handshake.
  initial begin
    int acc_cyc = 0;
    int lat_meas = 0;
    logic vld_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (ap_rst) begin
        vld_prev = 1'b0;
      end else begin
        if (bus_if.dout_vld && !vld_prev) lat_meas = cyc - acc_cyc;
        if (bus_if.dout_vld && bus_if.dout_rdy) begin
          if (sb_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("dout", 64'(bus_if.dout), 64'(e.dout));
            check("rem", 64'(bus_if.rem), 64'(e.rem));
            check("dbz", 64'(bus_if.dbz), 64'(e.dbz));
            check("latency", 64'(lat_meas), 64'(e.lat));
          end
        end
        vld_prev = bus_if.dout_vld;
        if (bus_if.din_vld && bus_if.din_rdy) acc_cyc = cyc;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [5:0] b, input logic [31:0] q,
                       input logic [6:0] r, input logic z, input int lat, input bit push);
    exp_t e;
    int   n = 0;
    while (!bus_if.din_rdy && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (!bus_if.din_rdy) check("din_rdy_timeout", 64'd0, 64'd1);
    bus_if.din_vld = 1'b1;
    bus_if.din0    = a;
    bus_if.din1    = b;
    if (push) begin
      e.dout = q; e.rem = r; e.dbz = z; e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge ap_clk); #1;
    bus_if.din_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus_if.din_vld  = 1'b0;
    bus_if.din0     = '0;
    bus_if.din1     = '0;
    bus_if.dout_rdy = 1'b1;
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    check("rst_din_rdy", 64'(bus_if.din_rdy), 64'd1);
    check("rst_dout_vld", 64'(bus_if.dout_vld), 64'd0);
    check("rst_dout", 64'(bus_if.dout), 64'd0);
    check("rst_rem", 64'(bus_if.rem), 64'd0);
    check("rst_dbz", 64'(bus_if.dbz), 64'd0);

    issue(32'd100, 6'd7, 32'd14, 7'd2, 1'b0, LAT_N, 1'b1);                      drain();
    issue(-32'sd100, 6'd7, 32'hFFFF_FFF2, 7'h7E, 1'b0, LAT_N, 1'b1);            drain();
    issue(32'h8000_0000, 6'd1, 32'h8000_0000, 7'd0, 1'b0, LAT_FP, 1'b1);        drain();
    issue(32'd12345, 6'd0, 32'hFFFF_FFFF, 7'd0, 1'b1, LAT_FP, 1'b1);            drain();
    issue(32'd5, 6'd63, 32'd0, 7'd5, 1'b0, LAT_FP, 1'b1);                       drain();
    issue(-32'sd7, 6'd2, 32'hFFFF_FFFD, 7'h7F, 1'b0, LAT_N, 1'b1);              drain();
    issue(32'h7FFF_FFFF, 6'd63, 32'd34087042, 7'd1, 1'b0, LAT_N, 1'b1);         drain();
    issue(32'h8000_0000, 6'd63, 32'hFDF7_DF7E, 7'h7E, 1'b0, LAT_N, 1'b1);       drain();

    // Backpressure: hold the result for 5 cycles, then a single-cycle accept.
    bus_if.dout_rdy = 1'b0;
    issue(32'd1000, 6'd10, 32'd100, 7'd0, 1'b0, LAT_N, 1'b1);
    n = 0;
    while (!bus_if.dout_vld && n < 100) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check("bp_vld_seen", 64'(bus_if.dout_vld), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk); #1;
      check("bp_hold_dout", 64'(bus_if.dout), 64'd100);
      check("bp_hold_rem", 64'(bus_if.rem), 64'd0);
      check("bp_hold_vld", 64'(bus_if.dout_vld), 64'd1);
      check("bp_hold_din_rdy", 64'(bus_if.din_rdy), 64'd0);
    end
    bus_if.dout_rdy = 1'b1;
    @(posedge ap_clk); #1;
    bus_if.dout_rdy = 1'b0;
    check("bp_release_din_rdy", 64'(bus_if.din_rdy), 64'd1);
    check("bp_release_vld", 64'(bus_if.dout_vld), 64'd0);
    check("bp_idle_dout_kept", 64'(bus_if.dout), 64'd100);
    bus_if.dout_rdy = 1'b1;
    issue(32'd63, 6'd63, 32'd1, 7'd0, 1'b0, LAT_N, 1'b1);                       drain();

    // Reset during CALC discards the operation.
    issue(32'd999, 6'd5, 32'd0, 7'd0, 1'b0, LAT_N, 1'b0);
    repeat (9) begin
      @(posedge ap_clk); #1;
    end
    check("mid_calc_busy", 64'(bus_if.din_rdy), 64'd0);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    check("mid_rst_din_rdy", 64'(bus_if.din_rdy), 64'd1);
    check("mid_rst_vld", 64'(bus_if.dout_vld), 64'd0);
    check("mid_rst_dout", 64'(bus_if.dout), 64'd0);
    check("mid_rst_rem", 64'(bus_if.rem), 64'd0);
    issue(32'd64, 6'd8, 32'd8, 7'd0, 1'b0, LAT_N, 1'b1);                        drain();

    repeat (3) @(posedge ap_clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
